// File: rtl/pacman_pkg.sv
// Shared pacman types: screen points, map rectangles and default colours.
// Imported by the movement, draw and raster blocks.
package pacman_pkg;

    localparam int MAP_NUM_RECTS = 21;
    localparam int DEF_COLOR_W = 3;

    localparam logic [2:0] DEF_WALL_COLOR = 3'b001;
    localparam logic [2:0] DEF_PAC_COLOR  = 3'b110;
    localparam logic [2:0] DEF_BG_COLOR   = 3'b000;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } point_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
    } rect_t;

    typedef enum logic [2:0] {
        S_wall_fetch,
        S_wall_wait,
        S_wall_draw,
        S_idle,
        S_erase,
        S_draw
    } state_t;

    localparam rect_t PAC_START = '{
        x0: 10'd240,
        y0: 9'd300,
        x1: 10'd265,
        y1: 9'd325
    };

    function automatic logic rect_empty(input rect_t r);
        return (r.x0 > r.x1) || (r.y0 > r.y1);
    endfunction

    function automatic rect_t make_rect(input point_t tl,
                                        input point_t br);
        rect_t r;
        r.x0 = tl.x;
        r.y0 = tl.y;
        r.x1 = br.x;
        r.y1 = br.y;
        return r;
    endfunction

endpackage

// File: rtl/box_raster.sv
// Inclusive raster walk over one box, one pixel per accepted handshake.
// Position and valid hold while the consumer stalls.
module box_raster
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  rect_t      box,
    input  logic       fb_ready,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       valid,
    output logic       last
);

    logic [9:0] x0;
    logic [9:0] x1;
    logic [8:0] y1;
    logic       row_end;

    assign row_end = (x == x1);
    assign last = valid && fb_ready && row_end && (y == y1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            x0    <= '0;
            x1    <= '0;
            y1    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            x     <= box.x0;
            y     <= box.y0;
            x0    <= box.x0;
            x1    <= box.x1;
            y1    <= box.y1;
            valid <= !rect_empty(box);
        end else if (valid && fb_ready) begin
            if (last) begin
                valid <= 1'b0;
            end else if (row_end) begin
                x <= x0;
                y <= y + 9'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

endmodule

// File: rtl/pacman_draw.sv
// Framebuffer painter: walls once after reset, then per frame erase the
// previous pacman box and paint the new one.
module pacman_draw
    import pacman_pkg::*;
#(
    parameter int                   NUM_RECTS  = MAP_NUM_RECTS,
    parameter int                   COLOR_W    = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0]   WALL_COLOR = DEF_WALL_COLOR,
    parameter logic [COLOR_W-1:0]   PAC_COLOR  = DEF_PAC_COLOR,
    parameter logic [COLOR_W-1:0]   BG_COLOR   = DEF_BG_COLOR
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [18:0]        pacman_top_left,
    input  logic [18:0]        pacman_bottom_right,
    output logic [4:0]         rect_addr,
    input  logic [37:0]        curr_rect,
    output logic [9:0]         fb_x,
    output logic [8:0]         fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic               busy,
    output logic               walls_done
);

    state_t             ps;
    logic [4:0]         i;
    rect_t              prev;
    rect_t              cur;
    rect_t              snap;
    rect_t              rom_rect;
    rect_t              draw_box;
    rect_t              load_box;
    logic [COLOR_W-1:0] load_color;
    logic               load;
    logic               last;
    logic               accept;
    logic               erase_done;
    logic               wall_adv;
    logic               last_rect;

    assign snap = make_rect(point_t'(pacman_top_left),
                            point_t'(pacman_bottom_right));
    assign rom_rect   = rect_t'(curr_rect);
    assign accept     = (ps == S_idle) && frame_start;
    assign last_rect  = (i == 5'(NUM_RECTS - 1));
    assign draw_box   = accept ? snap : cur;
    assign erase_done = (accept && rect_empty(prev))
                     || ((ps == S_erase) && last);
    assign rect_addr  = i;
    assign busy       = (ps != S_idle);

    // Raster load requests; an empty box skips straight to the next step.
    always_comb begin
        load       = 1'b0;
        load_box   = rom_rect;
        load_color = WALL_COLOR;
        wall_adv   = 1'b0;
        unique case (ps)
            S_wall_wait: begin
                load     = !rect_empty(rom_rect);
                wall_adv = rect_empty(rom_rect);
            end
            S_wall_draw: wall_adv = last;
            S_idle, S_erase: begin
                if (accept && !rect_empty(prev)) begin
                    load       = 1'b1;
                    load_box   = prev;
                    load_color = BG_COLOR;
                end else if (erase_done && !rect_empty(draw_box)) begin
                    load       = 1'b1;
                    load_box   = draw_box;
                    load_color = PAC_COLOR;
                end
            end
            default: ;
        endcase
    end

    // ctrl
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps         <= S_wall_fetch;
            i          <= '0;
            walls_done <= 1'b0;
        end else begin
            unique case (ps)
                S_wall_fetch: ps <= S_wall_wait;
                S_wall_wait, S_wall_draw: begin
                    if (wall_adv) begin
                        if (last_rect) begin
                            walls_done <= 1'b1;
                            ps         <= S_idle;
                        end else begin
                            i  <= i + 5'd1;
                            ps <= S_wall_fetch;
                        end
                    end else if (ps == S_wall_wait) begin
                        ps <= S_wall_draw;
                    end
                end
                S_idle: begin
                    if (accept) begin
                        if (!rect_empty(prev))
                            ps <= S_erase;
                        else if (!rect_empty(snap))
                            ps <= S_draw;
                    end
                end
                S_erase: begin
                    if (last)
                        ps <= rect_empty(cur) ? S_idle : S_draw;
                end
                S_draw: begin
                    if (last)
                        ps <= S_idle;
                end
                default: ps <= S_idle;
            endcase
        end
    end

    // dp
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev     <= PAC_START;
            cur      <= PAC_START;
            fb_color <= BG_COLOR;
        end else begin
            if (accept)
                cur <= snap;
            if (load)
                fb_color <= load_color;
            if (erase_done && rect_empty(draw_box))
                prev <= draw_box;
            if ((ps == S_draw) && last)
                prev <= cur;
        end
    end

    box_raster u_raster (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .box      (load_box),
        .fb_ready (fb_ready),
        .x        (fb_x),
        .y        (fb_y),
        .valid    (fb_we),
        .last     (last)
    );

endmodule

// File: tb/tb_pacman_draw.sv
// Randomized bench for pacman_draw with a pixel-list reference model.
// Expected pixels are generated from box geometry and frame rules.
module tb_pacman_draw;
    import pacman_pkg::*;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
    } box_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [18:0] pac_tl = '0;
    logic [18:0] pac_br = '0;
    logic [4:0]  rect_addr;
    logic [37:0] curr_rect = '0;
    logic [9:0]  fb_x;
    logic [8:0]  fb_y;
    logic [2:0]  fb_color;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        walls_done;

    logic [37:0] rom [21];
    box_t        rom_box [21];
    logic [21:0] expq [$];
    box_t        mprev;

    int n_chk = 0;
    int n_fail = 0;
    int nxfer = 0;
    int n_pushed = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    logic rdy_rand = 1'b0;
    logic hold_pending = 1'b0;
    logic [22:0] hold_val = '0;

    pacman_draw dut (
        .clk                 (clk),
        .reset               (reset),
        .frame_start         (frame_start),
        .pacman_top_left     (pac_tl),
        .pacman_bottom_right (pac_br),
        .rect_addr           (rect_addr),
        .curr_rect           (curr_rect),
        .fb_x                (fb_x),
        .fb_y                (fb_y),
        .fb_color            (fb_color),
        .fb_we               (fb_we),
        .fb_ready            (fb_ready),
        .busy                (busy),
        .walls_done          (walls_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        curr_rect <= rom[rect_addr];
    end

    initial forever begin
        @(posedge clk);
        #1;
        fb_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Framebuffer-side monitor: ordered scoreboard plus stall stability.
    always @(negedge clk) begin
        check("addr_range", 64'(rect_addr < 5'd21), 64'd1);
        if (hold_pending)
            check("stall_hold", {fb_we, fb_x, fb_y, fb_color}, hold_val);
        if (fb_we && fb_ready) begin
            nxfer++;
            last_xfer_cyc = cyc;
            if (expq.size() == 0)
                check("px_extra", nxfer, n_pushed);
            else
                check("px", {fb_x, fb_y, fb_color}, expq.pop_front());
        end
        hold_pending = fb_we && !fb_ready;
        hold_val = {fb_we, fb_x, fb_y, fb_color};
    end

    task automatic push_box(input box_t b, input logic [2:0] c);
        for (int yy = b.y0; yy <= b.y1; yy++)
            for (int xx = b.x0; xx <= b.x1; xx++) begin
                expq.push_back({10'(xx), 9'(yy), c});
                n_pushed++;
            end
    endtask

    task automatic set_rect(input int k, input box_t b);
        rom_box[k] = b;
        rom[k] = {10'(b.x0), 9'(b.y0), 10'(b.x1), 9'(b.y1)};
    endtask

    task automatic restart_model(output int n);
        n_pushed -= expq.size();
        expq.delete();
        for (int k = 0; k < 21; k++)
            push_box(rom_box[k], DEF_WALL_COLOR);
        n = expq.size();
        mprev = '{240, 300, 265, 325};
    endtask

    function automatic box_t rand_box();
        box_t b;
        b.x0 = int'($urandom_range(0, 620));
        b.y0 = int'($urandom_range(0, 460));
        b.x1 = b.x0 + int'($urandom_range(0, 15));
        b.y1 = b.y0 + int'($urandom_range(0, 15));
        return b;
    endfunction

    // Call at a negedge with the DUT idle.
    task automatic frame(input box_t b);
        pac_tl = {10'(b.x0), 9'(b.y0)};
        pac_br = {10'(b.x1), 9'(b.y1)};
        frame_start = 1'b1;
        push_box(mprev, DEF_BG_COLOR);
        push_box(b, DEF_PAC_COLOR);
        mprev = b;
        @(negedge clk);
        frame_start = 1'b0;
        check("first_px_lat", fb_we, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!busy && expq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done"}, 64'(ok), 1);
        if (ok)
            check({tag, "_busy_fall"}, 64'(cyc - last_xfer_cyc), 1);
    endtask

    task automatic wait_walls(input int base, input int exp_n);
        bit ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (walls_done) begin
                ok = 1;
                break;
            end
        end
        check("walls_done", 64'(ok), 1);
        check("wall_xfers", 64'(nxfer - base), 64'(exp_n));
        check("walls_idle", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   n_w;
        int   n_e;
        bit   found;
        box_t b;
        box_t s;

        set_rect(0, '{0, 0, 1, 1});
        for (int k = 1; k < 21; k++)
            set_rect(k, '{10, 10, 10, 10});

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", fb_we, 0);
        check("rst_addr", rect_addr, 0);
        check("rst_walls_done", walls_done, 0);
        check("rst_busy", busy, 1);
        check("rst_x", fb_x, 0);
        check("rst_y", fb_y, 0);
        check("rst_color", fb_color, DEF_BG_COLOR);
        restart_model(n_w);
        base = nxfer;
        reset = 1'b1;
        wait_walls(base, 24);

        base = nxfer;
        frame('{241, 300, 266, 325});
        wait_idle("f1");
        check("f1_xfers", 64'(nxfer - base), 1352);

        base = nxfer;
        rdy_rand = 1'b1;
        frame('{241, 300, 266, 325});
        wait_idle("stall");
        rdy_rand = 1'b0;
        check("stall_xfers", 64'(nxfer - base), 1352);

        // Ignored pulse and input change while drawing.
        n_e = (mprev.x1 - mprev.x0 + 1) * (mprev.y1 - mprev.y0 + 1);
        s = '{100, 50, 109, 59};
        frame(s);
        repeat (n_e + 3) @(negedge clk);
        check("mid_busy", busy, 1);
        pac_tl = {10'd300, 9'd200};
        pac_br = {10'd320, 9'd220};
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle("mid");
        repeat (3) @(negedge clk);
        check("pulse_dropped", busy, 0);

        for (int f = 0; f < 6; f++) begin
            rdy_rand = 1'($urandom_range(0, 1));
            b = (f % 3 == 2) ? mprev : rand_box();
            frame(b);
            wait_idle("rnd");
        end
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 21; k++) begin
            b = rand_box();
            b.x1 = b.x0 + int'($urandom_range(0, 3));
            b.y1 = b.y0 + int'($urandom_range(0, 3));
            set_rect(k, b);
        end
        set_rect(5, '{20, 20, 22, 22});
        set_rect(7, '{50, 40, 45, 44});
        set_rect(9, '{60, 70, 61, 65});
        reset = 1'b0;
        @(negedge clk);
        restart_model(n_w);
        reset = 1'b1;

        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rect_addr == 5'd5 && fb_we) begin
                found = 1;
                break;
            end
        end
        check("rect5_seen", 64'(found), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_we", fb_we, 0);
        check("midrst_addr", rect_addr, 0);
        check("midrst_walls_done", walls_done, 0);
        restart_model(n_w);
        base = nxfer;
        reset = 1'b1;
        wait_walls(base, n_w);

        frame(rand_box());
        wait_idle("p2");
        check("queue_empty", 64'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pacman_draw.md
Name: pacman_draw

Overview:
- Framebuffer writer that consumes the pacman bounding box produced by the movement block, plus the shared map ROM rectangle list.
- After reset it paints every wall rectangle once.
- On each frame tick it erases pacman's previous box to background and paints the new box.
- Pixels are emitted one per accepted handshake to the framebuffer port.

Parameters:
- NUM_RECTS, 21, number of wall rectangles in map ROM (addresses 0..NUM_RECTS-1).
- COLOR_W, 3, framebuffer colour width.
- WALL_COLOR, 3'b001, colour for wall pixels.
- PAC_COLOR, 3'b110, colour for pacman pixels.
- BG_COLOR, 3'b000, background colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- frame_start  in  1  one-cycle pulse per frame (vsync-derived)
- pacman_top_left  in  19  {x[9:0], y[8:0]} of pacman box, inclusive
- pacman_bottom_right  in  19  {x[9:0], y[8:0]} inclusive
- rect_addr  out  5  map ROM address
- curr_rect  in  38  ROM data {x0[9:0], y0[8:0], x1[9:0], y1[8:0]}, valid 1 cycle after rect_addr
- fb_x  out  10  pixel x
- fb_y  out  9  pixel y
- fb_color  out  COLOR_W  pixel colour
- fb_we  out  1  pixel valid
- fb_ready  in  1  framebuffer accepts pixel
- busy  out  1  high whenever not in S_idle
- walls_done  out  1  sticky high once the initial wall paint completes

Behaviour:
- Reset (reset==0 at posedge) from any state, including mid-rectangle:
  - Go to S_wall_fetch.
  - Outputs: rect_addr=0, fb_we=0, fb_x=0, fb_y=0, fb_color=BG_COLOR, walls_done=0, busy=1.
  - prev box = {240,300}-{265,325}.
- Handshake:
  - A pixel transfers on a cycle with fb_we & fb_ready.
  - While fb_we=1 and fb_ready=0, fb_x, fb_y and fb_color hold stable.
  - fb_we never drops without a transfer, except on reset.
- Pixel order: raster within the box, x0..x1 on row y0, then the next row, through (x1,y1). Bounds are inclusive.
  - Box pixel count = (x1-x0+1)*(y1-y0+1).
  - Degenerate boxes with x0>x1 or y0>y1 emit zero pixels and advance immediately.
- States:
  - S_wall_fetch: drive rect_addr=i, go to S_wall_wait.
  - S_wall_wait: one-cycle ROM latency. Latch curr_rect into the box registers, go to S_wall_draw.
  - S_wall_draw: emit WALL_COLOR pixels.
    - After the last pixel transfers: if i==NUM_RECTS-1, set walls_done=1 and go to S_idle.
    - Otherwise i<=i+1 and go to S_wall_fetch.
  - S_idle: fb_we=0. On frame_start, snapshot both pacman inputs into cur box registers, go to S_erase.
  - S_erase: emit prev box in BG_COLOR, then go to S_draw.
  - S_draw: emit cur box in PAC_COLOR. After the last pixel, prev<=cur and go to S_idle.
- frame_start outside S_idle is ignored (dropped, not queued).
- A frame_start in the same cycle the FSM enters S_idle is also ignored. It is accepted only when ps==S_idle.
- Pacman inputs are sampled only at the frame_start acceptance cycle. Later input changes do not affect the frame in progress.
- Identical prev and cur boxes still run both erase and draw.
- Erase/draw latency with fb_ready tied high: first pixel fb_we=1 in the cycle after frame_start acceptance; one pixel per cycle thereafter.
- Widths:
  - x counters are 10 bits, y counters 9 bits; row wrap is at x==x1.
  - Use no arithmetic beyond +1, so there is no overflow inside valid boxes (x≤639, y≤479).
  - i is 5 bits and must never address ≥NUM_RECTS.

Decomposition:
- Shared package pacman_pkg:
  - rect_t packed struct {x0, y0, x1, y1} matching the 38-bit ROM layout.
  - point_t {x[9:0], y[8:0]}.
  - MAP_NUM_RECTS = 21.
  - Colour constants.
- The movement block should also import pacman_pkg.
- Sub-module box_raster:
  - Inputs: load, box, fb_ready.
  - Outputs: x, y, valid, last.
  - Owns the per-box x/y counters, the inclusive-bound walk and the stall hold. It is instantiated once and reused by all three painting states.
- Control FSM and datapath are split as ctrl/dp, in the same style as the movement block.

Test Plan:
- Reset with fb_ready=1 and a ROM model holding rect0=(0,0)-(1,1) and rects 1..20=(10,10)-(10,10):
  - Expect 4 WALL pixels (0,0),(1,0),(0,1),(1,1).
  - Then 20 single pixels at (10,10).
  - walls_done rises after the 24th transfer.
  - No pixel is emitted in ROM-wait cycles.
- After walls_done, frame_start with pacman box (241,300)-(266,325):
  - Expect 676 BG pixels over (240,300)-(265,325).
  - Then 676 PAC pixels starting at (241,300) and ending at (266,325).
  - busy falls the cycle after the last pixel.
- fb_ready toggled randomly 50% during erase:
  - Every stalled cycle holds fb_x, fb_y and fb_color unchanged.
  - Total transfers are still 1352 with no duplicates or gaps.
- frame_start pulsed mid-draw, and pacman inputs changed mid-frame:
  - The pulse is ignored.
  - The drawn box equals the value sampled at acceptance.
  - The next accepted frame erases that sampled box.
- reset asserted low mid-wall-draw at rect 5:
  - Next cycle fb_we=0, rect_addr=0, walls_done=0.
  - The wall sequence restarts from rect0.
- Degenerate ROM entry x0>x1:
  - Zero pixels are emitted for that rect, and i advances to the next fetch without hanging.
